sram_port_arbiter: RTL and testbench

//  Shares one single-port 512x64 SRAM macro (active-low CEB/WEB/BWEB, Q read-before-write) between two

---
 rtl/sram_arb_pkg.sv | 20 ++
 rtl/sram_arb_rsp_slot.sv | 33 +++
 rtl/sram_port_arbiter.sv | 106 ++++++++++
 tb/tb_sram_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared widths and helpers for the two-port SRAM arbiter.
// Byte-mask expansion lives here so every user agrees on lane order.
package sram_arb_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 9;
  localparam int NBYTES     = DATA_WIDTH / 8;

  // Active-high byte enables -> active-low per-bit macro write mask.
  function automatic logic [DATA_WIDTH-1:0] expand_bweb(
    input logic [NBYTES-1:0] bmask
  );
    logic [DATA_WIDTH-1:0] b;
    b = '1;
    for (int i = 0; i < NBYTES; i++)
      b[i*8 +: 8] = {8{~bmask[i]}};
    return b;
  endfunction

endpackage

// File: rtl/sram_arb_rsp_slot.sv
// One read-response slot: in-flight flag plus a held response register.
// The macro Q is captured the cycle after the access; the slot may pop and reload at once.
module sram_arb_rsp_slot #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue,
  input  logic                  rsp_ready,
  input  logic [DATA_WIDTH-1:0] sram_q,
  output logic                  inflight,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata
);

  // Track the access, capture Q one cycle later, hold until consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      inflight <= issue;
      if (inflight) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= sram_q;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM macro between two requesters.
// Grant and macro pins are combinational; read responses come from per-port slots.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = sram_arb_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = sram_arb_pkg::ADDR_WIDTH,
  localparam int NBYTES    = DATA_WIDTH / 8,
  parameter logic [1:0] RTSEL_VAL = 2'b00,
  parameter logic [1:0] WTSEL_VAL = 2'b00
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  input  logic [2*NBYTES-1:0]     req_bmask,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic [2*DATA_WIDTH-1:0] rsp_rdata,
  output logic                    sram_ceb,
  output logic                    sram_web,
  output logic [ADDR_WIDTH-1:0]   sram_a,
  output logic [DATA_WIDTH-1:0]   sram_d,
  output logic [DATA_WIDTH-1:0]   sram_bweb,
  input  logic [DATA_WIDTH-1:0]   sram_q,
  output logic [1:0]              sram_rtsel,
  output logic [1:0]              sram_wtsel
);

  logic [1:0] inflight;
  logic [1:0] elig;
  logic [1:0] grant;
  logic       rr;
  logic       sel;

  assign sram_rtsel = RTSEL_VAL;
  assign sram_wtsel = WTSEL_VAL;
  assign req_ready  = grant;
  assign sel        = grant[1];

  // Reads wait for a free slot; writes never wait on response state.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 2; i++)
      elig[i] = req_valid[i] &&
                (req_write[i] ||
                 (!inflight[i] && (!rsp_valid[i] || rsp_ready[i])));
  end

  // Pick the pointed-to port on contention, otherwise whoever is eligible.
  always_comb begin
    grant = elig;
    if (reset)
      grant = '0;
    else if (&elig)
      grant = rr ? 2'b10 : 2'b01;
  end

  // Pointer moves to the port that lost this cycle.
  always_ff @(posedge clk) begin
    if (reset)
      rr <= 1'b0;
    else if (|grant)
      rr <= grant[0];
  end

  // Drive the macro from the granted port, quiet pins when idle.
  always_comb begin
    sram_ceb  = 1'b1;
    sram_web  = 1'b1;
    sram_a    = '0;
    sram_d    = '0;
    sram_bweb = '1;
    if (|grant) begin
      sram_ceb = 1'b0;
      sram_a   = sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                     : req_addr[ADDR_WIDTH-1:0];
      if (req_write[sel]) begin
        sram_web  = 1'b0;
        sram_d    = sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                        : req_wdata[DATA_WIDTH-1:0];
        sram_bweb = expand_bweb(sel ? req_bmask[2*NBYTES-1:NBYTES]
                                    : req_bmask[NBYTES-1:0]);
      end
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_slot
    sram_arb_rsp_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .issue     (grant[i] & ~req_write[i]),
      .rsp_ready (rsp_ready[i]),
      .sram_q    (sram_q),
      .inflight  (inflight[i]),
      .rsp_valid (rsp_valid[i]),
      .rsp_rdata (rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural macro, reference memory and response scoreboard.
// Directed scenarios first, then randomized traffic on a small address window.
module tb_sram_port_arbiter;

  localparam int DW = 64;
  localparam int AW = 9;
  localparam int NB = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req_valid, req_ready, req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata, rsp_rdata;
  logic [2*NB-1:0] req_bmask;
  logic [1:0]      rsp_valid, rsp_ready;
  logic            sram_ceb, sram_web;
  logic [AW-1:0]   sram_a;
  logic [DW-1:0]   sram_d, sram_bweb;
  logic [DW-1:0]   sram_q = '0;
  logic [1:0]      sram_rtsel, sram_wtsel;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          expq [2][$];
  logic [DW-1:0] mem     [512] = '{default: '0};
  logic [DW-1:0] ref_mem [512] = '{default: '0};
  logic [1:0]    acc_prev = 2'b00;

  sram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_bmask(req_bmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .sram_ceb(sram_ceb), .sram_web(sram_web),
    .sram_a(sram_a), .sram_d(sram_d),
    .sram_bweb(sram_bweb), .sram_q(sram_q),
    .sram_rtsel(sram_rtsel), .sram_wtsel(sram_wtsel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port macro: Q shows the pre-write word, bit-masked writes.
  always @(posedge clk) begin
    if (!sram_ceb) begin
      sram_q <= mem[sram_a];
      if (!sram_web)
        mem[sram_a] <= (mem[sram_a] & sram_bweb) | (sram_d & ~sram_bweb);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Monitor: predicts grant, pins and responses from the rules.
  initial begin : monitor
    logic [1:0]    el, eg;
    int            p;
    logic          rd_ok, avail;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, ebw, bm;
    logic          ew, ece;
    int            prio;
    exp_t          e;
    prio = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_ceb", 64'(sram_ceb), 64'h1);
        expq[0].delete();
        expq[1].delete();
        prio     = 0;
        acc_prev = 2'b00;
      end else begin
        for (int i = 0; i < 2; i++) begin
          rd_ok = (expq[i].size() == 0) ||
                  (expq[i].size() == 1 && expq[i][0].cyc <= cyc - 2 &&
                   rsp_ready[i]);
          el[i] = req_valid[i] && (req_write[i] || rd_ok);
        end
        if (el == 2'b11) eg = (prio == 0) ? 2'b01 : 2'b10;
        else             eg = el;
        chk("grant", 64'(req_ready), 64'(eg));

        ece = 1'b1; ew = 1'b1; ea = '0; ed = '0; ebw = '1; bm = '0;
        p = eg[1] ? 1 : 0;
        if (eg != 2'b00) begin
          ece = 1'b0;
          ea  = req_addr[p*AW +: AW];
          if (req_write[p]) begin
            ew = 1'b0;
            ed = req_wdata[p*DW +: DW];
            for (int b = 0; b < NB; b++) begin
              bm[b*8 +: 8]  = {8{req_bmask[p*NB + b]}};
              ebw[b*8 +: 8] = {8{~req_bmask[p*NB + b]}};
            end
          end
        end
        chk("sram_ceb", 64'(sram_ceb), 64'(ece));
        chk("sram_web", 64'(sram_web), 64'(ew));
        chk("sram_a", 64'(sram_a), 64'(ea));
        chk("sram_d", sram_d, ed);
        chk("sram_bweb", sram_bweb, ebw);

        for (int i = 0; i < 2; i++) begin
          avail = expq[i].size() > 0 && expq[i][0].cyc <= cyc - 2;
          chk($sformatf("rsp_valid%0d", i), 64'(rsp_valid[i]),
              64'(avail));
          if (avail && rsp_valid[i])
            chk($sformatf("rsp_data%0d", i), rsp_rdata[i*DW +: DW],
                expq[i][0].data);
          if (avail && rsp_ready[i])
            void'(expq[i].pop_front());
        end

        if (eg != 2'b00) begin
          if (req_write[p]) begin
            ref_mem[ea] = (ref_mem[ea] & ~bm) | (ed & bm);
          end else begin
            e.data = ref_mem[ea];
            e.cyc  = cyc;
            expq[p].push_back(e);
          end
          prio = (p == 0) ? 1 : 0;
        end
        acc_prev = req_valid & req_ready;
      end
    end
  end

  // Present one request from port p and wait (bounded) for its accept.
  task automatic issue(input int p, input logic w, input int a,
                       input logic [63:0] d, input logic [7:0] m);
    int acc;
    req_valid[p]          = 1'b1;
    req_write[p]          = w;
    req_addr[p*AW +: AW]  = a[AW-1:0];
    req_wdata[p*DW +: DW] = d;
    req_bmask[p*NB +: NB] = m;
    acc = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready[p]) begin
        acc = cyc;
        break;
      end
    end
    chk("accept", 64'(acc >= 0), 64'h1);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
  endtask

  initial begin : stim
    logic [1:0] prev;
    reset     = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_bmask = '0;
    rsp_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // full write then read-back, with latency check
    issue(0, 1'b1, 5, 64'h1122334455667788, 8'hFF);
    issue(0, 1'b0, 5, 64'h0, 8'h00);
    @(negedge clk);
    chk("t1_lat1", 64'(rsp_valid[0]), 64'h0);
    @(negedge clk);
    chk("t1_lat2", 64'(rsp_valid[0]), 64'h1);
    chk("t1_data", rsp_rdata[63:0], 64'h1122334455667788);
    @(posedge clk); #1;

    // single-lane partial write
    issue(0, 1'b1, 5, 64'hFFFFFFFFFFFFFFFF, 8'h01);
    issue(0, 1'b0, 5, 64'h0, 8'h00);
    repeat (2) @(negedge clk);
    chk("t2_data", rsp_rdata[63:0], 64'h11223344556677FF);
    @(posedge clk); #1;

    // both ports streaming reads
    req_write = 2'b00;
    req_addr  = {9'd6, 9'd5};
    req_valid = 2'b11;
    prev      = 2'b00;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("t3_ceb", 64'(sram_ceb), 64'h0);
      chk("t3_alt", 64'((req_ready == 2'b01 || req_ready == 2'b10) &&
                        req_ready != prev), 64'h1);
      prev = req_ready;
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (4) @(posedge clk);
    #1;

    // held response on p1 blocks reads but not writes
    issue(1, 1'b1, 6, 64'hA5A5A5A55A5A5A5A, 8'hFF);
    rsp_ready = 2'b01;
    issue(1, 1'b0, 6, 64'h0, 8'h00);
    repeat (2) @(negedge clk);
    chk("t4_held", 64'(rsp_valid[1]), 64'h1);
    @(posedge clk); #1;
    issue(1, 1'b1, 7, 64'hDEADBEEFCAFEF00D, 8'hF0);
    req_write[1]   = 1'b0;
    req_addr[17:9] = 9'd7;
    req_valid[1]   = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("t4_stall", 64'(req_ready[1]), 64'h0);
      chk("t4_stable", rsp_rdata[127:64], 64'hA5A5A5A55A5A5A5A);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("t4_release", 64'(req_ready[1]), 64'h1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (4) @(posedge clk);
    #1;

    // reset right after a read accept
    issue(0, 1'b0, 5, 64'h0, 8'h00);
    reset     = 1'b1;
    req_write = 2'b00;
    req_addr  = {9'd6, 9'd5};
    req_valid = 2'b11;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("t5_ceb", 64'(sram_ceb), 64'h1);
      chk("t5_ready", 64'(req_ready), 64'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_first", 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (4) @(posedge clk);
    #1;

    // idle pins and tie-offs
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      chk("t6_ceb", 64'(sram_ceb), 64'h1);
      chk("t6_web", 64'(sram_web), 64'h1);
      chk("t6_bweb", sram_bweb, 64'hFFFFFFFFFFFFFFFF);
      chk("t6_rtsel", 64'(sram_rtsel), 64'h0);
      chk("t6_wtsel", 64'(sram_wtsel), 64'h0);
    end
    @(posedge clk); #1;

    // randomized traffic, requests held until accepted
    for (int n = 0; n < 800; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!(req_valid[p] && !acc_prev[p])) begin
          req_valid[p]          = ($urandom_range(0, 3) != 0);
          req_write[p]          = ($urandom_range(0, 2) == 0);
          req_addr[p*AW +: AW]  = 9'($urandom_range(0, 15));
          req_wdata[p*DW +: DW] = {$urandom, $urandom};
          req_bmask[p*NB +: NB] = 8'($urandom_range(0, 255));
        end
      end
      rsp_ready[0] = ($urandom_range(0, 3) != 0);
      rsp_ready[1] = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end

    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (6) @(posedge clk);
    #1;
    chk("drain0", 64'(expq[0].size()), 64'h0);
    chk("drain1", 64'(expq[1].size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
